register_file_scoreboard: RTL and testbench

//  Parametrised multi-port register file for the pipelined core. Provides NUM_RD read ports and
//  NUM_WR write-back ports with same-cycle write-through bypass.

---
 rtl/register_file_scoreboard.sv | 156 +++++++++++++++
 tb/tb_register_file_scoreboard.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : register_file_scoreboard
// Description : Multi-port register file with write-through bypass and a
//               pending-write (busy bit) scoreboard. Optional stored parity
//               is enabled by defining RF_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module register_file_scoreboard #(
    parameter int WIDTH     = 32,
    parameter int ADD_WIDTH = 5,
    parameter int NUM_RD    = 2,
    parameter int NUM_WR    = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_WR-1:0]           write_enable,
    input  logic [NUM_WR*ADD_WIDTH-1:0] write_address,
    input  logic [NUM_WR*WIDTH-1:0]     write_data,
    input  logic [NUM_RD*ADD_WIDTH-1:0] read_address,
    output logic [NUM_RD*WIDTH-1:0]     read_data,
    output logic [NUM_RD-1:0]           read_busy,
    input  logic                        issue_valid,
    input  logic [ADD_WIDTH-1:0]        issue_address,
    output logic                        issue_stall,
    input  logic                        clear_all,
    output logic [ADD_WIDTH:0]          busy_count,
    input  logic                        parity_inject,
    output logic [NUM_RD-1:0]           parity_error
);

    localparam int c_depth = 1 << ADD_WIDTH;

    logic [WIDTH-1:0]     r_rf [c_depth];
    logic [c_depth-1:0]   r_busy;
    logic [ADD_WIDTH:0]   r_busy_count;

    logic [c_depth-1:0]   w_clear;
    logic [c_depth-1:0]   w_set;
    logic [c_depth-1:0]   w_busy_next;
    logic                 w_issue_stall;

    function automatic logic [ADD_WIDTH:0] f_popcount(input logic [c_depth-1:0] v);
        logic [ADD_WIDTH:0] cnt;
        cnt = '0;
        for (int i = 0; i < c_depth; i++) begin
            cnt = cnt + (ADD_WIDTH+1)'(v[i]);
        end
        return cnt;
    endfunction

    // One bit per register that is being written back this cycle.
    always_comb begin
        w_clear = '0;
        for (int p = 0; p < NUM_WR; p++) begin
            if (write_enable[p] && (write_address[p*ADD_WIDTH +: ADD_WIDTH] != '0)) begin
                w_clear[write_address[p*ADD_WIDTH +: ADD_WIDTH]] = 1'b1;
            end
        end
    end

    assign w_issue_stall = issue_valid && r_busy[issue_address] && !w_clear[issue_address];

    // Set is applied after clear so a same-cycle younger writer keeps the bit.
    always_comb begin
        w_set = '0;
        if (issue_valid && (issue_address != '0) && !w_issue_stall && !clear_all) begin
            w_set[issue_address] = 1'b1;
        end
        if (clear_all) begin
            w_busy_next = '0;
        end else begin
            w_busy_next = (r_busy & ~w_clear) | w_set;
        end
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < c_depth; i++) begin
                r_rf[i] <= '0;
            end
            r_busy       <= '0;
            r_busy_count <= '0;
        end else begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (write_enable[p] && (write_address[p*ADD_WIDTH +: ADD_WIDTH] != '0)) begin
                    r_rf[write_address[p*ADD_WIDTH +: ADD_WIDTH]] <= write_data[p*WIDTH +: WIDTH];
                end
            end
            r_busy       <= w_busy_next;
            r_busy_count <= f_popcount(w_busy_next);
        end
    end

`ifdef RF_PARITY_EN
    logic [c_depth-1:0] r_par;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_par <= '0;
        end else begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (write_enable[p] && (write_address[p*ADD_WIDTH +: ADD_WIDTH] != '0)) begin
                    r_par[write_address[p*ADD_WIDTH +: ADD_WIDTH]] <=
                        (^write_data[p*WIDTH +: WIDTH]) ^ parity_inject;
                end
            end
        end
    end
`else
    logic w_unused_parity_inject;
    assign w_unused_parity_inject = parity_inject;
`endif

    generate
        for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
            logic [ADD_WIDTH-1:0] w_ra;
            logic [WIDTH-1:0]     w_rdata;
            logic                 w_bypass;

            assign w_ra = read_address[r*ADD_WIDTH +: ADD_WIDTH];

            // Ascending scan: the highest-index matching write port wins.
            always_comb begin
                w_rdata  = r_rf[w_ra];
                w_bypass = 1'b0;
                for (int p = 0; p < NUM_WR; p++) begin
                    if (write_enable[p] && (w_ra != '0) &&
                        (write_address[p*ADD_WIDTH +: ADD_WIDTH] == w_ra)) begin
                        w_rdata  = write_data[p*WIDTH +: WIDTH];
                        w_bypass = 1'b1;
                    end
                end
                if (w_ra == '0) begin
                    w_rdata = '0;
                end
            end

            assign read_data[r*WIDTH +: WIDTH] = w_rdata;
            assign read_busy[r]                = r_busy[w_ra] && !w_bypass;

`ifdef RF_PARITY_EN
            assign parity_error[r] = (w_ra != '0) && !w_bypass &&
                                     ((^r_rf[w_ra]) != r_par[w_ra]);
`else
            assign parity_error[r] = 1'b0;
`endif
        end
    endgenerate

    assign issue_stall = w_issue_stall;
    assign busy_count  = r_busy_count;

endmodule
`default_nettype wire

// File: tb/tb_register_file_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_file_scoreboard
// Description : Self-checking bench for register_file_scoreboard: directed
//               scenarios plus randomized traffic against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file_scoreboard;

    localparam int W  = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int NW = 2;
    localparam int D  = 1 << AW;

    logic              clk = 1'b0;
    logic              reset;
    logic [NW-1:0]     write_enable;
    logic [NW*AW-1:0]  write_address;
    logic [NW*W-1:0]   write_data;
    logic [NR*AW-1:0]  read_address;
    logic [NR*W-1:0]   read_data;
    logic [NR-1:0]     read_busy;
    logic              issue_valid;
    logic [AW-1:0]     issue_address;
    logic              issue_stall;
    logic              clear_all;
    logic [AW:0]       busy_count;
    logic              parity_inject;
    logic [NR-1:0]     parity_error;

    always #5 clk = ~clk;

    register_file_scoreboard #(
        .WIDTH(W), .ADD_WIDTH(AW), .NUM_RD(NR), .NUM_WR(NW)
    ) dut (
        .clk(clk), .reset(reset),
        .write_enable(write_enable), .write_address(write_address), .write_data(write_data),
        .read_address(read_address), .read_data(read_data), .read_busy(read_busy),
        .issue_valid(issue_valid), .issue_address(issue_address), .issue_stall(issue_stall),
        .clear_all(clear_all), .busy_count(busy_count),
        .parity_inject(parity_inject), .parity_error(parity_error)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [W-1:0] rf_m [D];
    bit           busy_m [D];
    bit           par_m [D];

    task automatic idle();
        write_enable  = '0;
        write_address = '0;
        write_data    = '0;
        issue_valid   = 1'b0;
        issue_address = '0;
        clear_all     = 1'b0;
        parity_inject = 1'b0;
    endtask

    task automatic wr(input int p, input logic [AW-1:0] a, input logic [W-1:0] d);
        write_enable[p]        = 1'b1;
        write_address[p*AW +: AW] = a;
        write_data[p*W +: W]      = d;
    endtask

    task automatic rd(input int r, input logic [AW-1:0] a);
        read_address[r*AW +: AW] = a;
    endtask

    function automatic bit written(input logic [AW-1:0] a);
        for (int p = 0; p < NW; p++)
            if (write_enable[p] && a != 0 && write_address[p*AW +: AW] == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [W-1:0] m_read(input logic [AW-1:0] a);
        if (a == 0) return '0;
        for (int p = NW-1; p >= 0; p--)
            if (write_enable[p] && write_address[p*AW +: AW] == a) return write_data[p*W +: W];
        return rf_m[a];
    endfunction

    function automatic bit m_stall();
        return issue_valid && busy_m[issue_address] && !written(issue_address);
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int a = 0; a < D; a++) c += busy_m[a];
        return c;
    endfunction

    function automatic bit m_perr(input logic [AW-1:0] a);
`ifdef RF_PARITY_EN
        return (a != 0) && !written(a) && ((^rf_m[a]) != par_m[a]);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        for (int a = 0; a < D; a++) begin
            rf_m[a] = '0; busy_m[a] = 1'b0; par_m[a] = 1'b0;
        end
    endtask

    // Advance model with the current inputs, then clock the DUT.
    task automatic tick();
        bit st;
        bit wmask [D];
        st = m_stall();
        for (int a = 0; a < D; a++) wmask[a] = written(AW'(a));
        for (int p = 0; p < NW; p++) begin
            if (write_enable[p] && write_address[p*AW +: AW] != 0) begin
                rf_m[write_address[p*AW +: AW]]  = write_data[p*W +: W];
                par_m[write_address[p*AW +: AW]] = (^write_data[p*W +: W]) ^ parity_inject;
            end
        end
        if (clear_all) begin
            for (int a = 0; a < D; a++) busy_m[a] = 1'b0;
        end else begin
            for (int a = 0; a < D; a++) if (wmask[a]) busy_m[a] = 1'b0;
            if (issue_valid && issue_address != 0 && !st) busy_m[issue_address] = 1'b1;
        end
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle();
        read_address = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        for (int a = 0; a < D; a++) begin
            rd(0, AW'(a));
            rd(1, AW'(D-1-a));
            #1;
            n_cmp++;
            if (read_data !== '0 || read_busy !== '0 || parity_error !== '0) begin
                n_bad++;
                $display("FAIL reset_read a=%0d: data=%h busy=%b perr=%b, required 0", a, read_data, read_busy, parity_error);
            end
        end
        n_cmp++;
        if (busy_count !== '0) begin
            n_bad++;
            $display("FAIL reset_count: got %0d required 0", busy_count);
        end
    endtask

    task automatic test_bypass();
        wr(0, 5, 32'hDEADBEEF);
        rd(0, 5);
        #1;
        n_cmp++;
        if (read_data[0 +: W] !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL bypass_read: got %h required deadbeef", read_data[0 +: W]);
        end
        tick();
        rd(0, 5);
        #1;
        n_cmp++;
        if (read_data[0 +: W] !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL stored_read: got %h required deadbeef", read_data[0 +: W]);
        end
    endtask

    task automatic test_write_priority();
        wr(0, 7, 32'h11);
        wr(1, 7, 32'h22);
        rd(0, 7);
        #1;
        n_cmp++;
        if (read_data[0 +: W] !== 32'h22) begin
            n_bad++;
            $display("FAIL prio_bypass: got %h required 22", read_data[0 +: W]);
        end
        tick();
        rd(0, 7);
        wr(0, 0, 32'hFF);
        rd(1, 0);
        #1;
        n_cmp++;
        if (read_data[0 +: W] !== 32'h22 || read_data[W +: W] !== '0) begin
            n_bad++;
            $display("FAIL prio_stored_or_r0: got p0=%h p1=%h required 22 / 0", read_data[0 +: W], read_data[W +: W]);
        end
        tick();
        rd(1, 0);
        #1;
        n_cmp++;
        if (read_data[W +: W] !== '0) begin
            n_bad++;
            $display("FAIL r0_after_write: got %h required 0", read_data[W +: W]);
        end
    endtask

    task automatic test_scoreboard();
        issue_valid = 1'b1; issue_address = 3;
        #1;
        n_cmp++;
        if (issue_stall !== 1'b0) begin
            n_bad++;
            $display("FAIL first_issue_stall: got %b required 0", issue_stall);
        end
        tick();
        rd(0, 3);
        #1;
        n_cmp++;
        if (busy_count !== 1 || read_busy[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL issue_busy: count=%0d busy=%b required 1 / 1", busy_count, read_busy[0]);
        end
        issue_valid = 1'b1; issue_address = 3;
        #1;
        n_cmp++;
        if (issue_stall !== 1'b1) begin
            n_bad++;
            $display("FAIL waw_stall: got %b required 1", issue_stall);
        end
        tick();
        wr(0, 3, 32'hAB);
        issue_valid = 1'b1; issue_address = 3;
        rd(0, 3);
        #1;
        n_cmp++;
        if (issue_stall !== 1'b0 || read_busy[0] !== 1'b0 || read_data[0 +: W] !== 32'hAB) begin
            n_bad++;
            $display("FAIL wb_issue_same: stall=%b busy=%b data=%h required 0 / 0 / ab", issue_stall, read_busy[0], read_data[0 +: W]);
        end
        tick();
        rd(0, 3);
        #1;
        n_cmp++;
        if (busy_count !== 1 || read_busy[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL set_wins: count=%0d busy=%b required 1 / 1", busy_count, read_busy[0]);
        end
        wr(1, 3, 32'hAC);
        tick();
        n_cmp++;
        if (busy_count !== 0) begin
            n_bad++;
            $display("FAIL wb_clears: count=%0d required 0", busy_count);
        end
    endtask

    task automatic test_clear_all();
        for (int a = 1; a <= 4; a++) begin
            issue_valid = 1'b1; issue_address = AW'(a);
            tick();
        end
        n_cmp++;
        if (busy_count !== 4) begin
            n_bad++;
            $display("FAIL four_issues: count=%0d required 4", busy_count);
        end
        clear_all = 1'b1; issue_valid = 1'b1; issue_address = 9;
        tick();
        rd(0, 9);
        rd(1, 5);
        #1;
        n_cmp++;
        if (busy_count !== 0 || read_busy[0] !== 1'b0 || read_data[W +: W] !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL clear_all: count=%0d busy9=%b rf5=%h required 0 / 0 / deadbeef", busy_count, read_busy[0], read_data[W +: W]);
        end
    endtask

    task automatic test_parity();
        logic exp_err;
`ifdef RF_PARITY_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        wr(0, 6, 32'h1);
        parity_inject = 1'b1;
        tick();
        rd(0, 6);
        #1;
        n_cmp++;
        if (parity_error[0] !== exp_err || read_data[0 +: W] !== 32'h1) begin
            n_bad++;
            $display("FAIL parity_inject: perr=%b data=%h required %b / 1", parity_error[0], read_data[0 +: W], exp_err);
        end
        wr(1, 6, 32'h2);
        #1;
        n_cmp++;
        if (parity_error[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL parity_bypassed: got %b required 0", parity_error[0]);
        end
        tick();
        rd(0, 6);
        #1;
        n_cmp++;
        if (parity_error[0] !== 1'b0 || read_data[0 +: W] !== 32'h2) begin
            n_bad++;
            $display("FAIL parity_rewrite: perr=%b data=%h required 0 / 2", parity_error[0], read_data[0 +: W]);
        end
    endtask

    task automatic test_random();
        // Mid-operation asynchronous reset with writes pending
        issue_valid = 1'b1; issue_address = 12;
        tick();
        wr(0, 12, 32'h55);
        rd(0, 7);
        reset = 1'b0;
        #1;
        model_reset();
        n_cmp++;
        if (busy_count !== 0 || read_data[0 +: W] !== '0) begin
            n_bad++;
            $display("FAIL async_reset: count=%0d rf7=%h required 0 / 0", busy_count, read_data[0 +: W]);
        end
        @(posedge clk);
        #1;
        idle();
        reset = 1'b1;
        for (int c = 0; c < 600; c++) begin
            for (int p = 0; p < NW; p++) begin
                write_enable[p]           = ($urandom_range(0, 2) == 0);
                write_address[p*AW +: AW] = AW'($urandom_range(0, 9));
                write_data[p*W +: W]      = W'($urandom);
            end
            for (int r = 0; r < NR; r++) rd(r, AW'($urandom_range(0, 11)));
            issue_valid   = ($urandom_range(0, 1) == 1);
            issue_address = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 9));
            clear_all     = ($urandom_range(0, 19) == 0);
            parity_inject = ($urandom_range(0, 3) == 0);
            #1;
            for (int r = 0; r < NR; r++) begin
                n_cmp++;
                if (read_data[r*W +: W] !== m_read(read_address[r*AW +: AW]) ||
                    read_busy[r] !== (busy_m[read_address[r*AW +: AW]] && !written(read_address[r*AW +: AW])) ||
                    parity_error[r] !== m_perr(read_address[r*AW +: AW])) begin
                    n_bad++;
                    $display("FAIL rand_read c=%0d r=%0d a=%0d: data=%h busy=%b perr=%b required %h / %b / %b",
                             c, r, read_address[r*AW +: AW], read_data[r*W +: W], read_busy[r], parity_error[r],
                             m_read(read_address[r*AW +: AW]),
                             busy_m[read_address[r*AW +: AW]] && !written(read_address[r*AW +: AW]),
                             m_perr(read_address[r*AW +: AW]));
                end
            end
            n_cmp++;
            if (issue_stall !== m_stall()) begin
                n_bad++;
                $display("FAIL rand_stall c=%0d: got %b required %b", c, issue_stall, m_stall());
            end
            tick();
            n_cmp++;
            if (busy_count !== (AW+1)'(m_count())) begin
                n_bad++;
                $display("FAIL rand_count c=%0d: got %0d required %0d", c, busy_count, m_count());
            end
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_write_priority();
        test_scoreboard();
        test_clear_all();
        test_parity();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
